// File: rtl/crt_mode_pkg.sv
// Shared types and constants for crt_mode_sequencer.
// Defining CRT_MODE_SEQ_TIMEOUT_EN widens the shared counter for the vblank timeout.
package crt_mode_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_VB,
        BLANK,
        SWITCH,
        SETTLE,
        DONE
    } seq_state_t;

    typedef struct packed {
        logic       vga_mode;
        logic [1:0] bpp;
    } mode_t;

    localparam mode_t RESET_MODE = '{vga_mode: 1'b1, bpp: 2'b00};

`ifdef CRT_MODE_SEQ_TIMEOUT_EN
    localparam int CNT_W = 20;
`else
    localparam int CNT_W = 8;
`endif

endpackage

// File: rtl/crt_mode_seq_cnt.sv
// Shared down-counter for drain, settle and (optionally) vblank timeout.
// A load wins over counting; the counter parks at zero.
module crt_mode_seq_cnt
    import crt_mode_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic [CNT_W-1:0] value,
    output logic             zero
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (!zero) begin
            value <= value - 1'b1;
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/crt_mode_sequencer.sv
// Glitch-free CRT mode change: wait for vblank, blank, drain, switch the divider mode, settle.
// Defining CRT_MODE_SEQ_TIMEOUT_EN forces the switch after TIMEOUT_CYCLES without vblank.
module crt_mode_sequencer
    import crt_mode_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES   = 16,
    parameter int unsigned SETTLE_CYCLES  = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1048575
) (
    input  logic       pll_clock,
    input  logic       pix_reset,
    input  logic       req_valid,
    input  logic       req_vga_mode,
    input  logic [1:0] req_bpp,
    output logic       req_ready,
    input  logic       vblank,
    output logic       vga_mode_out,
    output logic [1:0] bpp_out,
    output logic       crt_blank,
    output logic       busy,
    output logic       done,
    output logic       timeout_flag
);

    seq_state_t       state, next_state;
    mode_t            pending, cur_mode, req_mode;
    logic             accept, apply_mode, set_timeout;
    logic             cnt_load, cnt_zero;
    logic [CNT_W-1:0] cnt_load_value, cnt_value_unused;

    assign req_mode = {req_vga_mode, req_bpp};

    crt_mode_seq_cnt u_cnt (
        .clk        (pll_clock),
        .rst        (pix_reset),
        .load       (cnt_load),
        .load_value (cnt_load_value),
        .value      (cnt_value_unused),
        .zero       (cnt_zero)
    );

    always_ff @(posedge pll_clock or posedge pix_reset) begin
        if (pix_reset) state <= IDLE;
        else           state <= next_state;
    end

    // Counters are loaded with N-1 on state entry so each phase lasts exactly N cycles.
    always_comb begin
        next_state     = state;
        accept         = 1'b0;
        apply_mode     = 1'b0;
        set_timeout    = 1'b0;
        cnt_load       = 1'b0;
        cnt_load_value = '0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (req_mode == cur_mode) begin
                        next_state = DONE;
                    end else begin
                        next_state = WAIT_VB;
`ifdef CRT_MODE_SEQ_TIMEOUT_EN
                        cnt_load       = 1'b1;
                        cnt_load_value = CNT_W'(TIMEOUT_CYCLES - 1);
`endif
                    end
                end
            end
            WAIT_VB: begin
                if (vblank) begin
                    next_state     = BLANK;
                    cnt_load       = 1'b1;
                    cnt_load_value = CNT_W'(DRAIN_CYCLES - 1);
                end
`ifdef CRT_MODE_SEQ_TIMEOUT_EN
                else if (cnt_zero) begin
                    next_state     = BLANK;
                    set_timeout    = 1'b1;
                    cnt_load       = 1'b1;
                    cnt_load_value = CNT_W'(DRAIN_CYCLES - 1);
                end
`endif
            end
            BLANK: begin
                if (cnt_zero) next_state = SWITCH;
            end
            SWITCH: begin
                apply_mode     = 1'b1;
                next_state     = SETTLE;
                cnt_load       = 1'b1;
                cnt_load_value = CNT_W'(SETTLE_CYCLES - 1);
            end
            SETTLE: begin
                if (cnt_zero) next_state = DONE;
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge pll_clock or posedge pix_reset) begin
        if (pix_reset) begin
            pending  <= RESET_MODE;
            cur_mode <= RESET_MODE;
        end else begin
            if (accept)     pending  <= req_mode;
            if (apply_mode) cur_mode <= pending;
        end
    end

`ifdef CRT_MODE_SEQ_TIMEOUT_EN
    always_ff @(posedge pll_clock or posedge pix_reset) begin
        if (pix_reset)        timeout_flag <= 1'b0;
        else if (accept)      timeout_flag <= 1'b0;
        else if (set_timeout) timeout_flag <= 1'b1;
    end
`else
    // Timeout limit has no effect when the feature is compiled out.
    localparam int unsigned TIMEOUT_UNUSED = TIMEOUT_CYCLES;
    logic set_timeout_unused;
    assign set_timeout_unused = set_timeout;
    assign timeout_flag       = 1'b0;
`endif

    assign vga_mode_out = cur_mode.vga_mode;
    assign bpp_out      = cur_mode.bpp;
    assign req_ready    = (state == IDLE);
    assign busy         = (state != IDLE);
    assign done         = (state == DONE);
    assign crt_blank    = (state == BLANK) || (state == SWITCH) || (state == SETTLE);

endmodule

// File: tb/tb_crt_mode_sequencer.sv
// Self-checking bench for crt_mode_sequencer; build with CRT_MODE_SEQ_TIMEOUT_EN to cover the timeout.
`timescale 1ns/1ps
module tb_crt_mode_sequencer;

    localparam int D  = 16;
    localparam int S  = 8;
    localparam int TO = 100;

    logic       pll_clock;
    logic       pix_reset;
    logic       req_valid;
    logic       req_vga_mode;
    logic [1:0] req_bpp;
    logic       req_ready;
    logic       vblank;
    logic       vga_mode_out;
    logic [1:0] bpp_out;
    logic       crt_blank;
    logic       busy;
    logic       done;
    logic       timeout_flag;

    int pass_count  = 0;
    int total_count = 0;

    logic [2:0] model_mode;

    typedef struct {
        logic [2:0] mode;
        int         lat;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic       vga;
        logic [1:0] bpp;
        int         vb_delay;
        bit         drop_vb;
        bit         exp_same;
    } vec_t;
    vec_t vecs[7];

    crt_mode_sequencer #(
        .DRAIN_CYCLES   (D),
        .SETTLE_CYCLES  (S),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .pll_clock    (pll_clock),
        .pix_reset    (pix_reset),
        .req_valid    (req_valid),
        .req_vga_mode (req_vga_mode),
        .req_bpp      (req_bpp),
        .req_ready    (req_ready),
        .vblank       (vblank),
        .vga_mode_out (vga_mode_out),
        .bpp_out      (bpp_out),
        .crt_blank    (crt_blank),
        .busy         (busy),
        .done         (done),
        .timeout_flag (timeout_flag)
    );

    initial begin
        pll_clock = 1'b0;
        forever #5 pll_clock = ~pll_clock;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge pll_clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    function automatic int expLatency(input bit same, input int vb_delay);
        return same ? 1 : vb_delay + D + S + 3;
    endfunction

    // Drive one request and follow it to its done pulse, checking blanking and mode timing.
    task automatic applyStimulus(input logic vga, input logic [1:0] bpp, input int vb_delay,
                                 input bit drop_vb, input bit hold_valid, input int exp_lat);
        logic [2:0] old_mode, new_mode;
        int rel, blank_cnt, first_blank, mode_err, ready_err, busy_err;
        int exp_first;
        bit got_done;
        sb_t exp;
        old_mode = model_mode;
        new_mode = {vga, bpp};
        sb.push_back('{mode: new_mode, lat: exp_lat});
        checkOutput("ready_before_req", 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_vga_mode = vga;
        req_bpp      = bpp;
        vblank       = (vb_delay == 0);
        tick();
        if (hold_valid) begin
            req_vga_mode = ~vga;
            req_bpp      = ~bpp;
        end else begin
            req_valid = 1'b0;
        end
        rel = 1; got_done = 0; blank_cnt = 0; first_blank = -1;
        mode_err = 0; ready_err = 0; busy_err = 0;
        while (!got_done && rel < 3000) begin
            if (rel == vb_delay + 1) vblank = 1'b1;
            if (drop_vb && rel == exp_lat - S - D + 2) vblank = 1'b0;
            if (crt_blank) begin
                blank_cnt++;
                if (first_blank < 0) first_blank = rel;
            end
            if ({vga_mode_out, bpp_out} !== ((rel >= exp_lat - S) ? new_mode : old_mode)) mode_err++;
            if (req_ready) ready_err++;
            if (done) begin
                got_done = 1;
            end else begin
                if (!busy) busy_err++;
                tick();
                rel++;
            end
        end
        req_valid = 1'b0;
        vblank    = 1'b0;
        checkOutput("done_seen", 32'(got_done), 32'd1);
        checkOutput("sb_nonempty", 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
            exp = sb.pop_front();
            checkOutput("sb_latency", 32'(rel), 32'(exp.lat));
            checkOutput("sb_mode", 32'({vga_mode_out, bpp_out}), 32'(exp.mode));
        end
        exp_first = (exp_lat == 1) ? -1 : exp_lat - S - D - 1;
        checkOutput("blank_count", 32'(blank_cnt), (exp_lat == 1) ? 32'd0 : 32'(D + S + 1));
        checkOutput("blank_start", 32'(first_blank), 32'(exp_first));
        checkOutput("mode_timing_errs", 32'(mode_err), 32'd0);
        checkOutput("ready_while_busy", 32'(ready_err), 32'd0);
        checkOutput("busy_errs", 32'(busy_err), 32'd0);
        tick();
        checkOutput("done_pulse_width", 32'(done), 32'd0);
        checkOutput("ready_after_done", 32'(req_ready), 32'd1);
        checkOutput("mode_held_idle", 32'({vga_mode_out, bpp_out}), 32'(new_mode));
        model_mode = new_mode;
        tick();
    endtask

    initial begin
        vecs[0] = '{vga: 1'b0, bpp: 2'b01, vb_delay: 50, drop_vb: 1'b0, exp_same: 1'b0};
        vecs[1] = '{vga: 1'b0, bpp: 2'b01, vb_delay: 3,  drop_vb: 1'b0, exp_same: 1'b1};
        vecs[2] = '{vga: 1'b1, bpp: 2'b11, vb_delay: 0,  drop_vb: 1'b1, exp_same: 1'b0};
        vecs[3] = '{vga: 1'b1, bpp: 2'b11, vb_delay: 0,  drop_vb: 1'b0, exp_same: 1'b1};
        vecs[4] = '{vga: 1'b1, bpp: 2'b00, vb_delay: 5,  drop_vb: 1'b0, exp_same: 1'b0};
        vecs[5] = '{vga: 1'b1, bpp: 2'b00, vb_delay: 0,  drop_vb: 1'b0, exp_same: 1'b1};
        vecs[6] = '{vga: 1'b0, bpp: 2'b00, vb_delay: 2,  drop_vb: 1'b1, exp_same: 1'b0};

        pix_reset    = 1'b0;
        req_valid    = 1'b0;
        req_vga_mode = 1'b0;
        req_bpp      = 2'b00;
        vblank       = 1'b0;
        model_mode   = 3'b100;
        #2 pix_reset = 1'b1;
        #1;
        checkOutput("rst_vga_mode", 32'(vga_mode_out), 32'd1);
        checkOutput("rst_bpp", 32'(bpp_out), 32'd0);
        checkOutput("rst_blank", 32'(crt_blank), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_timeout", 32'(timeout_flag), 32'd0);
        tick();
        tick();
        pix_reset = 1'b0;
        tick();
        checkOutput("ready_after_reset", 32'(req_ready), 32'd1);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].vga, vecs[i].bpp, vecs[i].vb_delay, vecs[i].drop_vb, 1'b0,
                          expLatency(vecs[i].exp_same, vecs[i].vb_delay));
        end

        // Request held high with changing data while busy: only the first is applied.
        applyStimulus(1'b0, 2'b11, 1, 1'b0, 1'b1, expLatency(1'b0, 1));

        // Reset pulsed in the middle of SETTLE.
        req_valid    = 1'b1;
        req_vga_mode = 1'b0;
        req_bpp      = 2'b10;
        vblank       = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 21; i++) tick();
        checkOutput("settle_blank", 32'(crt_blank), 32'd1);
        checkOutput("settle_mode", 32'({vga_mode_out, bpp_out}), 32'b010);
        pix_reset = 1'b1;
        #1;
        checkOutput("midrst_vga_mode", 32'(vga_mode_out), 32'd1);
        checkOutput("midrst_bpp", 32'(bpp_out), 32'd0);
        checkOutput("midrst_blank", 32'(crt_blank), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_done", 32'(done), 32'd0);
        tick();
        tick();
        pix_reset  = 1'b0;
        vblank     = 1'b0;
        model_mode = 3'b100;
        tick();
        checkOutput("ready_after_midrst", 32'(req_ready), 32'd1);
        applyStimulus(1'b0, 2'b10, 4, 1'b0, 1'b0, expLatency(1'b0, 4));

`ifdef CRT_MODE_SEQ_TIMEOUT_EN
        applyStimulus(1'b1, 2'b01, 100000, 1'b0, 1'b0, TO + D + S + 2);
        checkOutput("timeout_flag_set", 32'(timeout_flag), 32'd1);
        applyStimulus(1'b0, 2'b01, 0, 1'b0, 1'b0, expLatency(1'b0, 0));
        checkOutput("timeout_flag_cleared", 32'(timeout_flag), 32'd0);
`else
        checkOutput("timeout_flag_tied", 32'(timeout_flag), 32'd0);
`endif

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
